sys_ctrl_frame: RTL and testbench

// Parametrised frame-based system controller in the REF_CLK domain. Decodes

---
 rtl/sys_ctrl_pkg.sv | 19 +
 rtl/tx_byte_sender.sv | 88 ++++++++
 rtl/sys_ctrl_frame.sv | 219 +++++++++++++++++++++
 tb/tb_sys_ctrl_frame.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared command codes and controller state encoding for the REF_CLK-domain frame controller.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN,
    ALU_WAIT, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO
  } state_e;

  // States in which an incoming frame byte is expected and accepted.
  function automatic logic is_rx_state(input state_e s);
    return s inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN};
  endfunction

endpackage

// File: rtl/tx_byte_sender.sv
// Serialises up to NBYTES bytes, LSB byte first, over the busy-handshaked UART TX.
module tx_byte_sender
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NBYTES     = 2,
  parameter int IW         = $clog2(NBYTES + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NBYTES*DATA_WIDTH-1:0] data,
  input  logic [IW-1:0]                nbytes,
  input  logic                         tx_busy,
  output logic [DATA_WIDTH-1:0]        tx_p_data,
  output logic                         tx_d_vld,
  output logic                         done
);

  state_e                         state_q, state_d;
  logic [NBYTES*DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [IW-1:0]                  cnt_q, cnt_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [DATA_WIDTH-1:0]          tx_p_data_q, tx_p_data_d;
  logic                           tx_d_vld_q, tx_d_vld_d;
  logic                           done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      tx_p_data_q <= '0;
      tx_d_vld_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tx_p_data_q <= tx_p_data_d;
      tx_d_vld_q  <= tx_d_vld_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tx_p_data_d = tx_p_data_q;
    tx_d_vld_d  = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        shreg_d = data;
        cnt_d   = nbytes;
        idx_d   = '0;
        state_d = TX_LOAD;
      end
      TX_LOAD: if (!tx_busy) begin
        tx_p_data_d = shreg_q[DATA_WIDTH-1:0];
        tx_d_vld_d  = 1'b1;
        shreg_d     = shreg_q >> DATA_WIDTH;
        idx_d       = idx_q + IW'(1);
        state_d     = TX_WAIT_HI;
      end
      TX_WAIT_HI: if (tx_busy) state_d = TX_WAIT_LO;
      TX_WAIT_LO: if (!tx_busy) begin
        if (idx_q == cnt_q) begin
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          state_d = TX_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_p_data = tx_p_data_q;
  assign tx_d_vld  = tx_d_vld_q;
  assign done      = done_q;

endmodule

// File: rtl/sys_ctrl_frame.sv
// Frame-based system controller: decodes UART command frames, drives reg-file/ALU/clock gate,
// and returns read data, ALU results or an error code through tx_byte_sender.
module sys_ctrl_frame
  import sys_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDR_WIDTH    = 4,
  parameter int                    ALU_OUT_BYTES = 2,
  parameter int                    TIMEOUT_CYC   = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_CODE      = 'hEE
) (
  input  logic                                REF_CLK,
  input  logic                                SYNC_RST1,
  input  logic [DATA_WIDTH-1:0]               rx_p_data,
  input  logic                                rx_d_vld,
  input  logic [DATA_WIDTH-1:0]               rd_data,
  input  logic                                rd_data_vld,
  input  logic [ALU_OUT_BYTES*DATA_WIDTH-1:0] alu_out,
  input  logic                                alu_out_vld,
  input  logic                                tx_busy,
  output logic                                alu_en,
  output logic [3:0]                          alu_fun,
  output logic                                alu_clk_en,
  output logic [ADDR_WIDTH-1:0]               reg_addr,
  output logic                                reg_wr_en,
  output logic [DATA_WIDTH-1:0]               reg_wr_data,
  output logic                                reg_rd_en,
  output logic                                clk_div_en,
  output logic [DATA_WIDTH-1:0]               tx_p_data,
  output logic                                tx_d_vld,
  output logic                                frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int IW = $clog2(ALU_OUT_BYTES + 1);
  localparam int RW = ALU_OUT_BYTES * DATA_WIDTH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  alu_go_q, alu_go_d;
  logic                  alu_en_q, alu_en_d;
  logic [3:0]            alu_fun_q, alu_fun_d;
  logic                  alu_clk_en_q, alu_clk_en_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic                  reg_wr_en_q, reg_wr_en_d;
  logic [DATA_WIDTH-1:0] reg_wr_data_q, reg_wr_data_d;
  logic                  reg_rd_en_q, reg_rd_en_d;
  logic                  frame_err_q, frame_err_d;
  logic                  clk_div_en_q;
  logic                  tx_start, tx_done, send_err, rx_ok, tmo_hit;
  logic [RW-1:0]         tx_data;
  logic [IW-1:0]         tx_nbytes;

  always_ff @(posedge REF_CLK or negedge SYNC_RST1) begin
    if (!SYNC_RST1) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      tmo_q         <= '0;
      alu_go_q      <= 1'b0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      alu_clk_en_q  <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_data_q <= '0;
      reg_rd_en_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      clk_div_en_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      tmo_q         <= tmo_d;
      alu_go_q      <= alu_go_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      alu_clk_en_q  <= alu_clk_en_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_data_q <= reg_wr_data_d;
      reg_rd_en_q   <= reg_rd_en_d;
      frame_err_q   <= frame_err_d;
      clk_div_en_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    tmo_d         = tmo_q + TW'(1);
    alu_go_d      = 1'b0;
    alu_en_d      = alu_go_q;
    alu_fun_d     = alu_fun_q;
    alu_clk_en_d  = alu_clk_en_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_en_d   = 1'b0;
    reg_wr_data_d = reg_wr_data_q;
    reg_rd_en_d   = 1'b0;
    frame_err_d   = 1'b0;
    tx_start      = 1'b0;
    tx_data       = '0;
    tx_nbytes     = '0;
    send_err      = 1'b0;
    rx_ok         = rx_d_vld && (state_q == IDLE || is_rx_state(state_q));
    tmo_hit       = (tmo_q == TW'(TIMEOUT_CYC - 1));

    case (state_q)
      IDLE: if (rx_d_vld) begin
        if (rx_p_data == DATA_WIDTH'(CMD_WR))           state_d = WR_ADDR;
        else if (rx_p_data == DATA_WIDTH'(CMD_RD))      state_d = RD_ADDR;
        else if (rx_p_data == DATA_WIDTH'(CMD_ALU_OP))  state_d = ALU_A;
        else if (rx_p_data == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ALU_FUN;
        else begin
          frame_err_d = 1'b1;
          send_err    = 1'b1;
        end
      end
      WR_ADDR: if (rx_d_vld) begin
        addr_d  = rx_p_data[ADDR_WIDTH-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (rx_d_vld) begin
        reg_wr_en_d   = 1'b1;
        reg_addr_d    = addr_q;
        reg_wr_data_d = rx_p_data;
        state_d       = IDLE;
      end
      RD_ADDR: if (rx_d_vld) begin
        reg_rd_en_d = 1'b1;
        reg_addr_d  = rx_p_data[ADDR_WIDTH-1:0];
        state_d     = RD_WAIT;
      end
      // ALU operands are staged in reg-file locations 0 and 1.
      ALU_A: if (rx_d_vld) begin
        reg_wr_en_d   = 1'b1;
        reg_addr_d    = '0;
        reg_wr_data_d = rx_p_data;
        state_d       = ALU_B;
      end
      ALU_B: if (rx_d_vld) begin
        reg_wr_en_d   = 1'b1;
        reg_addr_d    = ADDR_WIDTH'(1);
        reg_wr_data_d = rx_p_data;
        state_d       = ALU_FUN;
      end
      ALU_FUN: if (rx_d_vld) begin
        alu_fun_d    = rx_p_data[3:0];
        alu_clk_en_d = 1'b1;
        alu_go_d     = 1'b1;
        state_d      = ALU_WAIT;
      end
      RD_WAIT: if (rd_data_vld) begin
        tx_start  = 1'b1;
        tx_data   = RW'(rd_data);
        tx_nbytes = IW'(1);
        state_d   = TX_LOAD;
      end else if (tmo_hit) begin
        frame_err_d = 1'b1;
        send_err    = 1'b1;
      end
      ALU_WAIT: if (alu_out_vld) begin
        tx_start     = 1'b1;
        tx_data      = alu_out;
        tx_nbytes    = IW'(ALU_OUT_BYTES);
        alu_clk_en_d = 1'b0;
        state_d      = TX_LOAD;
      end else if (tmo_hit) begin
        frame_err_d  = 1'b1;
        alu_clk_en_d = 1'b0;
        send_err     = 1'b1;
      end
      TX_LOAD: if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A stalled frame is abandoned silently; a byte arriving while busy is dropped.
    if (is_rx_state(state_q) && !rx_d_vld && tmo_hit) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
    end
    if (rx_d_vld && !rx_ok) frame_err_d = 1'b1;

    if (send_err) begin
      tx_start  = 1'b1;
      tx_data   = RW'(ERR_CODE);
      tx_nbytes = IW'(1);
      state_d   = TX_LOAD;
    end

    if (state_q == IDLE || state_q == TX_LOAD || rx_ok || state_d != state_q) tmo_d = '0;
  end

  tx_byte_sender #(
    .DATA_WIDTH(DATA_WIDTH),
    .NBYTES    (ALU_OUT_BYTES),
    .IW        (IW)
  ) u_tx (
    .clk      (REF_CLK),
    .rst_n    (SYNC_RST1),
    .start    (tx_start),
    .data     (tx_data),
    .nbytes   (tx_nbytes),
    .tx_busy  (tx_busy),
    .tx_p_data(tx_p_data),
    .tx_d_vld (tx_d_vld),
    .done     (tx_done)
  );

  assign alu_en      = alu_en_q;
  assign alu_fun     = alu_fun_q;
  assign alu_clk_en  = alu_clk_en_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_en   = reg_wr_en_q;
  assign reg_wr_data = reg_wr_data_q;
  assign reg_rd_en   = reg_rd_en_q;
  assign clk_div_en  = clk_div_en_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_sys_ctrl_frame.sv
// Directed self-checking bench for sys_ctrl_frame with a simple UART TX busy model.
module tb_sys_ctrl_frame;

  logic        REF_CLK = 1'b0;
  logic        SYNC_RST1 = 1'b0;
  logic [7:0]  rx_p_data = '0;
  logic        rx_d_vld = 1'b0;
  logic [7:0]  rd_data = '0;
  logic        rd_data_vld = 1'b0;
  logic [15:0] alu_out = '0;
  logic        alu_out_vld = 1'b0;
  logic        tx_busy;
  logic        alu_en, alu_clk_en, reg_wr_en, reg_rd_en, clk_div_en, tx_d_vld, frame_err;
  logic [3:0]  alu_fun, reg_addr;
  logic [7:0]  reg_wr_data, tx_p_data;
  logic        tx_model_en = 1'b1;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0, n_alu_en = 0, hs_viol = 0;
  int alu_en_cyc = 0, clk_rise_cyc = 0;
  logic [3:0] last_rd_addr = '0, fun_at_rise = '0;
  logic clk_en_at_alu_en = 1'b0, clk_en_prev = 1'b0, awaiting = 1'b0, seen_hi = 1'b0;
  logic [7:0] tx_log[$];
  logic [3:0] wr_addr_log[$];
  logic [7:0] wr_data_log[$];

  sys_ctrl_frame dut (
    .REF_CLK(REF_CLK), .SYNC_RST1(SYNC_RST1), .rx_p_data(rx_p_data), .rx_d_vld(rx_d_vld),
    .rd_data(rd_data), .rd_data_vld(rd_data_vld), .alu_out(alu_out), .alu_out_vld(alu_out_vld),
    .tx_busy(tx_busy), .alu_en(alu_en), .alu_fun(alu_fun), .alu_clk_en(alu_clk_en),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .reg_rd_en(reg_rd_en),
    .clk_div_en(clk_div_en), .tx_p_data(tx_p_data), .tx_d_vld(tx_d_vld), .frame_err(frame_err)
  );

  always #5 REF_CLK = ~REF_CLK;

  // Event recorder, sampling 2 time units after each rising edge.
  always begin
    @(posedge REF_CLK);
    #2;
    cyc++;
    if (reg_wr_en) begin
      n_wr++;
      wr_addr_log.push_back(reg_addr);
      wr_data_log.push_back(reg_wr_data);
    end
    if (reg_rd_en) begin n_rd++; last_rd_addr = reg_addr; end
    if (tx_d_vld) begin
      n_tx++;
      tx_log.push_back(tx_p_data);
      if (awaiting) hs_viol++;
      awaiting = 1'b1;
      seen_hi = 1'b0;
    end else if (awaiting) begin
      if (tx_busy) seen_hi = 1'b1;
      else if (seen_hi) awaiting = 1'b0;
    end
    if (frame_err) n_err++;
    if (alu_en) begin n_alu_en++; alu_en_cyc = cyc; clk_en_at_alu_en = alu_clk_en; end
    if (alu_clk_en && !clk_en_prev) begin clk_rise_cyc = cyc; fun_at_rise = alu_fun; end
    clk_en_prev = alu_clk_en;
    if (!SYNC_RST1) awaiting = 1'b0;
  end

  // UART TX model: goes busy 2 cycles after each strobe, stays busy 6 cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge REF_CLK);
      #3;
      if (tx_d_vld && tx_model_en) begin
        repeat (2) @(negedge REF_CLK);
        tx_busy = 1'b1;
        repeat (6) @(negedge REF_CLK);
        tx_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge REF_CLK);
    rx_p_data = b;
    rx_d_vld  = 1'b1;
    @(negedge REF_CLK);
    rx_d_vld  = 1'b0;
  endtask

  function automatic logic [7:0] tx_at(input int i);
    return (i < tx_log.size()) ? tx_log[i] : 8'hxx;
  endfunction

  function automatic logic [30:0] all_outs();
    return {alu_en, alu_fun, alu_clk_en, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en,
            clk_div_en, tx_p_data, tx_d_vld, frame_err};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge REF_CLK);
    n_checks++;
    if (all_outs() !== 31'd0) $display("FAIL reset_outs: got %h want 0", all_outs());
    else n_pass++;
    SYNC_RST1 = 1'b1;
    #1;
    n_checks++;
    if (clk_div_en !== 1'b0) $display("FAIL clk_div_en_early: got %b want 0", clk_div_en);
    else n_pass++;
    @(posedge REF_CLK);
    #2;
    n_checks++;
    if (clk_div_en !== 1'b1) $display("FAIL clk_div_en_rise: got %b want 1", clk_div_en);
    else n_pass++;
  endtask

  task automatic test_write();
    int wr0 = n_wr, tx0 = n_tx, err0 = n_err, idx = wr_addr_log.size();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    repeat (20) @(negedge REF_CLK);
    n_checks++;
    if (n_wr - wr0 !== 1) $display("FAIL wr_count: got %0d want 1", n_wr - wr0);
    else n_pass++;
    n_checks++;
    if (wr_addr_log.size() <= idx || wr_addr_log[idx] !== 4'h5 || wr_data_log[idx] !== 8'h3C)
      $display("FAIL wr_addr_data: got %0d entries want addr 5 data 3c", wr_addr_log.size() - idx);
    else n_pass++;
    n_checks++;
    if (n_tx - tx0 !== 0 || n_err - err0 !== 0)
      $display("FAIL wr_no_tx: got tx %0d err %0d want 0 0", n_tx - tx0, n_err - err0);
    else n_pass++;
  endtask

  task automatic test_read();
    int rd0 = n_rd, tx0 = n_tx, v0 = hs_viol;
    send_byte(8'hBB); send_byte(8'h05);
    for (int i = 0; i < 20 && n_rd == rd0; i++) @(negedge REF_CLK);
    n_checks++;
    if (n_rd - rd0 !== 1 || last_rd_addr !== 4'h5)
      $display("FAIL rd_strobe: got count %0d addr %0h want 1 5", n_rd - rd0, last_rd_addr);
    else n_pass++;
    repeat (2) @(negedge REF_CLK);
    rd_data = 8'h3C; rd_data_vld = 1'b1;
    @(negedge REF_CLK);
    rd_data_vld = 1'b0;
    repeat (40) @(negedge REF_CLK);
    n_checks++;
    if (n_tx - tx0 !== 1) $display("FAIL rd_tx_count: got %0d want 1", n_tx - tx0);
    else n_pass++;
    n_checks++;
    if (tx_at(tx0) !== 8'h3C) $display("FAIL rd_tx_byte: got %h want 3c", tx_at(tx0));
    else n_pass++;
    n_checks++;
    if (tx_p_data !== 8'h3C) $display("FAIL rd_tx_hold: got %h want 3c", tx_p_data);
    else n_pass++;
    n_checks++;
    if (hs_viol !== v0) $display("FAIL rd_handshake: got %0d violations want 0", hs_viol - v0);
    else n_pass++;
  endtask

  task automatic test_alu_op();
    int wr0 = n_wr, tx0 = n_tx, a0 = n_alu_en, v0 = hs_viol, idx = wr_addr_log.size();
    alu_out = 16'h001E;
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h02);
    for (int i = 0; i < 20 && n_alu_en == a0; i++) @(negedge REF_CLK);
    n_checks++;
    if (n_wr - wr0 !== 2 || wr_addr_log.size() < idx + 2 ||
        wr_addr_log[idx] !== 4'h0 || wr_data_log[idx] !== 8'h0A ||
        wr_addr_log[idx+1] !== 4'h1 || wr_data_log[idx+1] !== 8'h03)
      $display("FAIL alu_operand_writes: got %0d writes want (0,0a),(1,03)", n_wr - wr0);
    else n_pass++;
    n_checks++;
    if (n_alu_en - a0 !== 1 || fun_at_rise !== 4'h2)
      $display("FAIL alu_start: got en %0d fun %0h want 1 2", n_alu_en - a0, fun_at_rise);
    else n_pass++;
    n_checks++;
    if (alu_en_cyc - clk_rise_cyc !== 1 || clk_en_at_alu_en !== 1'b1)
      $display("FAIL alu_en_timing: got delta %0d want 1", alu_en_cyc - clk_rise_cyc);
    else n_pass++;
    repeat (3) @(negedge REF_CLK);
    alu_out_vld = 1'b1;
    @(negedge REF_CLK);
    alu_out_vld = 1'b0;
    n_checks++;
    if (alu_clk_en !== 1'b0) $display("FAIL alu_clk_en_drop: got %b want 0", alu_clk_en);
    else n_pass++;
    repeat (50) @(negedge REF_CLK);
    n_checks++;
    if (n_tx - tx0 !== 2 || tx_at(tx0) !== 8'h1E || tx_at(tx0 + 1) !== 8'h00)
      $display("FAIL alu_tx: got %0d bytes %h %h want 2 1e 00", n_tx - tx0, tx_at(tx0), tx_at(tx0 + 1));
    else n_pass++;
    n_checks++;
    if (hs_viol !== v0) $display("FAIL alu_handshake: got %0d violations want 0", hs_viol - v0);
    else n_pass++;
  endtask

  task automatic test_unknown();
    int tx0 = n_tx, err0 = n_err;
    send_byte(8'h77);
    repeat (30) @(negedge REF_CLK);
    n_checks++;
    if (n_err - err0 !== 1) $display("FAIL unk_err: got %0d want 1", n_err - err0);
    else n_pass++;
    n_checks++;
    if (n_tx - tx0 !== 1 || tx_at(tx0) !== 8'hEE)
      $display("FAIL unk_tx: got %0d bytes %h want 1 ee", n_tx - tx0, tx_at(tx0));
    else n_pass++;
  endtask

  task automatic test_timeout();
    int tx0 = n_tx, err0 = n_err, wr0 = n_wr, n = 0;
    send_byte(8'hAA); send_byte(8'h05);
    while (n_err == err0 && n < 1100) begin @(negedge REF_CLK); n++; end
    n_checks++;
    if (n < 1020 || n > 1028) $display("FAIL tmo_latency: got %0d cycles want about 1024", n);
    else n_pass++;
    repeat (10) @(negedge REF_CLK);
    n_checks++;
    if (n_err - err0 !== 1 || n_wr - wr0 !== 0 || n_tx - tx0 !== 0)
      $display("FAIL tmo_effects: got err %0d wr %0d tx %0d want 1 0 0", n_err - err0, n_wr - wr0, n_tx - tx0);
    else n_pass++;
    send_byte(8'hAA); send_byte(8'h07); send_byte(8'h44);
    repeat (5) @(negedge REF_CLK);
    n_checks++;
    if (n_wr - wr0 !== 1 || wr_addr_log[wr_addr_log.size()-1] !== 4'h7)
      $display("FAIL tmo_back_to_idle: got %0d writes want 1 to addr 7", n_wr - wr0);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int tx0 = n_tx, err0 = n_err;
    send_byte(8'hBB); send_byte(8'h02);
    repeat (2) @(negedge REF_CLK);
    send_byte(8'h99);
    repeat (3) @(negedge REF_CLK);
    n_checks++;
    if (n_err - err0 !== 1) $display("FAIL ovr_err: got %0d want 1", n_err - err0);
    else n_pass++;
    rd_data = 8'h5A; rd_data_vld = 1'b1;
    @(negedge REF_CLK);
    rd_data_vld = 1'b0;
    repeat (30) @(negedge REF_CLK);
    n_checks++;
    if (n_tx - tx0 !== 1 || tx_at(tx0) !== 8'h5A)
      $display("FAIL ovr_tx: got %0d bytes %h want 1 5a", n_tx - tx0, tx_at(tx0));
    else n_pass++;
  endtask

  task automatic test_reset_mid_tx();
    int tx0 = n_tx, a0 = n_alu_en, v0;
    tx_model_en = 1'b0;
    alu_out = 16'h1234;
    send_byte(8'hDD); send_byte(8'h00);
    for (int i = 0; i < 20 && n_alu_en == a0; i++) @(negedge REF_CLK);
    alu_out_vld = 1'b1;
    @(negedge REF_CLK);
    alu_out_vld = 1'b0;
    for (int i = 0; i < 20 && n_tx == tx0; i++) @(negedge REF_CLK);
    repeat (2) @(negedge REF_CLK);
    SYNC_RST1 = 1'b0;
    #2;
    n_checks++;
    if (all_outs() !== 31'd0) $display("FAIL midrst_outs: got %h want 0", all_outs());
    else n_pass++;
    repeat (3) @(negedge REF_CLK);
    SYNC_RST1 = 1'b1;
    tx_model_en = 1'b1;
    repeat (20) @(negedge REF_CLK);
    n_checks++;
    if (n_tx - tx0 !== 1) $display("FAIL midrst_no_tx: got %0d want 1", n_tx - tx0);
    else n_pass++;
    tx0 = n_tx; a0 = n_alu_en; v0 = hs_viol;
    alu_out = 16'h5678;
    send_byte(8'hDD); send_byte(8'h00);
    for (int i = 0; i < 20 && n_alu_en == a0; i++) @(negedge REF_CLK);
    n_checks++;
    if (n_alu_en - a0 !== 1 || fun_at_rise !== 4'h0)
      $display("FAIL nop_start: got en %0d fun %0h want 1 0", n_alu_en - a0, fun_at_rise);
    else n_pass++;
    alu_out_vld = 1'b1;
    @(negedge REF_CLK);
    alu_out_vld = 1'b0;
    repeat (50) @(negedge REF_CLK);
    n_checks++;
    if (n_tx - tx0 !== 2 || tx_at(tx0) !== 8'h78 || tx_at(tx0 + 1) !== 8'h56 || hs_viol !== v0)
      $display("FAIL nop_tx: got %0d bytes %h %h want 2 78 56", n_tx - tx0, tx_at(tx0), tx_at(tx0 + 1));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu_op();
    test_unknown();
    test_timeout();
    test_overrun();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
